// File: rtl/adsr_envelope_bank.sv
`default_nettype none
// ============================================================================
// Module   : adsr_envelope_bank
// Purpose  : Time-multiplexed ADSR envelope generator. Each accepted
//            sample_tick starts a scan that updates one voice per clock and
//            streams (voice, level) pairs downstream. Rates and sustain level
//            are shared by all voices and programmed over Wishbone.
// Ports    : clk, rst_n            - clock, async active-low reset
//            wb_*                  - Wishbone slave (one wait state)
//            voice_gate            - per-voice gate from voice manager
//            sample_tick           - one-cycle sample-rate strobe
//            env_valid/voice/level - envelope sample stream
// Revision : 1.0 - initial release
// ============================================================================
module adsr_envelope_bank #(
    parameter int NUM_VOICES = 8,
    parameter int LEVEL_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    input  logic [NUM_VOICES-1:0] voice_gate,
    input  logic                  sample_tick,
    output logic                  env_valid,
    output logic [3:0]            env_voice,
    output logic [LEVEL_W-1:0]    env_level
);

    localparam int                 IDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_VOICES - 1);
    localparam logic [LEVEL_W-1:0] MAX_LEVEL = '1;

    typedef enum logic [2:0] {
        V_IDLE    = 3'd0,
        V_ATTACK  = 3'd1,
        V_DECAY   = 3'd2,
        V_SUSTAIN = 3'd3,
        V_RELEASE = 3'd4
    } vstate_t;

    typedef enum logic {
        SCAN_IDLE = 1'b0,
        SCAN_RUN  = 1'b1
    } scan_t;

    // Programmable registers
    logic               ctrl_enable;
    logic [LEVEL_W-1:0] attack_rate, decay_rate, sustain_lvl, release_rate;
    logic               ovr;

    // Per-voice context
    vstate_t               vstate [NUM_VOICES];
    logic [LEVEL_W-1:0]    level  [NUM_VOICES];
    logic [NUM_VOICES-1:0] prev_gate;

    // Scanner
    scan_t            scan_state, scan_next;
    logic [IDX_W-1:0] idx, idx_next, slot;
    logic             proc;

    // Voice datapath results
    logic               g;
    vstate_t            eff_st, new_st;
    logic [LEVEL_W-1:0] cur_lv, new_lv;
    logic [LEVEL_W:0]   att_sum, dec_floor;

    logic [5:0]  word;
    logic        wb_wr;
    logic [31:0] rd_data;
    logic [15:0] active;
    logic        unused_bits;

    assign word        = wb_adr_i[7:2];
    assign wb_wr       = wb_cyc_i & wb_stb_i & wb_we_i & wb_ack_o;
    assign unused_bits = ^{wb_adr_i, wb_dat_i};

    // ------------------------------------------------------------------
    // Scanner: the accepting tick processes voice 0 on the same edge so
    // voice k appears on the outputs k+1 cycles after the tick cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_state <= SCAN_IDLE;
            idx        <= '0;
        end else begin
            scan_state <= scan_next;
            idx        <= idx_next;
        end
    end

    always_comb begin
        scan_next = scan_state;
        idx_next  = idx;
        slot      = idx;
        proc      = 1'b0;
        case (scan_state)
            SCAN_IDLE: begin
                if (sample_tick && ctrl_enable) begin
                    proc = 1'b1;
                    slot = '0;
                end
            end
            SCAN_RUN: proc = 1'b1;
        endcase
        if (proc) begin
            if (slot == LAST_IDX) begin
                scan_next = SCAN_IDLE;
                idx_next  = '0;
            end else begin
                scan_next = SCAN_RUN;
                idx_next  = slot + IDX_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Envelope step for the voice in the current slot. Gate edges are
    // resolved first so the new phase's step applies in the same slot.
    // Comparisons use one extra bit so sums/thresholds never wrap.
    // ------------------------------------------------------------------
    always_comb begin
        g         = voice_gate[slot];
        cur_lv    = level[slot];
        eff_st    = vstate[slot];
        att_sum   = {1'b0, cur_lv} + {1'b0, attack_rate};
        dec_floor = {1'b0, sustain_lvl} + {1'b0, decay_rate};
        if (g && !prev_gate[slot]) begin
            eff_st = V_ATTACK;
        end else if (!g && (eff_st == V_ATTACK || eff_st == V_DECAY || eff_st == V_SUSTAIN)) begin
            eff_st = V_RELEASE;
        end
        new_st = eff_st;
        new_lv = cur_lv;
        case (eff_st)
            V_ATTACK: begin
                if (attack_rate == '0 || att_sum >= {1'b0, MAX_LEVEL}) begin
                    new_lv = MAX_LEVEL;
                    new_st = V_DECAY;
                end else begin
                    new_lv = att_sum[LEVEL_W-1:0];
                end
            end
            V_DECAY: begin
                // level - decay <= sustain, rearranged to avoid underflow
                if (decay_rate == '0 || {1'b0, cur_lv} <= dec_floor) begin
                    new_lv = sustain_lvl;
                    new_st = V_SUSTAIN;
                end else begin
                    new_lv = cur_lv - decay_rate;
                end
            end
            V_SUSTAIN: new_lv = sustain_lvl;
            V_RELEASE: begin
                if (release_rate == '0 || cur_lv <= release_rate) begin
                    new_lv = '0;
                    new_st = V_IDLE;
                end else begin
                    new_lv = cur_lv - release_rate;
                end
            end
            default: new_lv = cur_lv;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            env_valid <= 1'b0;
            env_voice <= '0;
            env_level <= '0;
            prev_gate <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                vstate[i] <= V_IDLE;
                level[i]  <= '0;
            end
        end else begin
            env_valid <= proc;
            if (proc) begin
                env_voice       <= 4'(slot);
                env_level       <= new_lv;
                vstate[slot]    <= new_st;
                level[slot]     <= new_lv;
                prev_gate[slot] <= g;
            end else begin
                env_voice <= '0;
                env_level <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Wishbone register file
    // ------------------------------------------------------------------
    for (genvar gv = 0; gv < 16; gv++) begin : g_active
        if (gv < NUM_VOICES) begin : g_used
            assign active[gv] = (vstate[gv] != V_IDLE);
        end else begin : g_unused
            assign active[gv] = 1'b0;
        end
    end

    always_comb begin
        rd_data = 32'hDEAD_BEEF;
        case (word)
            6'd0: rd_data = {31'b0, ctrl_enable};
            6'd1: rd_data = 32'(attack_rate);
            6'd2: rd_data = 32'(decay_rate);
            6'd3: rd_data = 32'(sustain_lvl);
            6'd4: rd_data = 32'(release_rate);
            6'd5: rd_data = {14'b0, (scan_state == SCAN_RUN), ovr, active};
            default: begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (word == 6'(8 + v)) begin
                        rd_data = {13'b0, vstate[v], 16'(level[v])};
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack_o     <= 1'b0;
            wb_dat_o     <= '0;
            ctrl_enable  <= 1'b1;
            attack_rate  <= LEVEL_W'(16'h0100);
            decay_rate   <= LEVEL_W'(16'h0040);
            sustain_lvl  <= LEVEL_W'(16'hC000);
            release_rate <= LEVEL_W'(16'h0020);
            ovr          <= 1'b0;
        end else begin
            wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o;
            if (wb_cyc_i && wb_stb_i && !wb_we_i) begin
                wb_dat_o <= rd_data;
            end
            if (wb_wr) begin
                case (word)
                    6'd0: ctrl_enable  <= wb_dat_i[0];
                    6'd1: attack_rate  <= wb_dat_i[LEVEL_W-1:0];
                    6'd2: decay_rate   <= wb_dat_i[LEVEL_W-1:0];
                    6'd3: sustain_lvl  <= wb_dat_i[LEVEL_W-1:0];
                    6'd4: release_rate <= wb_dat_i[LEVEL_W-1:0];
                    default: ;
                endcase
            end
            // A colliding overrun wins over the clear so it is never lost
            if (sample_tick && scan_state == SCAN_RUN) begin
                ovr <= 1'b1;
            end else if (wb_wr && word == 6'd5 && wb_dat_i[16]) begin
                ovr <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adsr_envelope_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_adsr_envelope_bank
// Purpose  : Self-checking bench for adsr_envelope_bank with a behavioural
//            envelope model (integer arithmetic per voice).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adsr_envelope_bank;

    localparam int NV  = 8;
    localparam int LW  = 16;
    localparam int MAX = 65535;

    logic          clk;
    logic          rst_n;
    logic          wb_cyc_i, wb_stb_i, wb_we_i;
    logic [31:0]   wb_adr_i, wb_dat_i, wb_dat_o;
    logic          wb_ack_o;
    logic [NV-1:0] voice_gate;
    logic          sample_tick;
    logic          env_valid;
    logic [3:0]    env_voice;
    logic [LW-1:0] env_level;

    adsr_envelope_bank #(.NUM_VOICES(NV), .LEVEL_W(LW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_cyc_i    (wb_cyc_i),
        .wb_stb_i    (wb_stb_i),
        .wb_we_i     (wb_we_i),
        .wb_adr_i    (wb_adr_i),
        .wb_dat_i    (wb_dat_i),
        .wb_dat_o    (wb_dat_o),
        .wb_ack_o    (wb_ack_o),
        .voice_gate  (voice_gate),
        .sample_tick (sample_tick),
        .env_valid   (env_valid),
        .env_voice   (env_voice),
        .env_level   (env_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_st [NV];
    int m_lv [NV];
    int m_pg [NV];
    int exp_lv [NV];
    int m_atk, m_dcy, m_sus, m_rel, m_en, m_ovr;
    logic [LW-1:0] last_v0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_st[i] = 0; m_lv[i] = 0; m_pg[i] = 0;
        end
        m_atk = 'h100; m_dcy = 'h40; m_sus = 'hC000; m_rel = 'h20;
        m_en = 1; m_ovr = 0;
    endtask

    // One full scan of the envelope rules over all voices
    task automatic model_scan();
        for (int k = 0; k < NV; k++) begin
            int gt;
            gt = int'(voice_gate[k]);
            if (gt == 1 && m_pg[k] == 0) m_st[k] = 1;
            else if (gt == 0 && m_st[k] >= 1 && m_st[k] <= 3) m_st[k] = 4;
            case (m_st[k])
                1: begin
                    if (m_atk == 0 || m_lv[k] + m_atk >= MAX) begin m_lv[k] = MAX; m_st[k] = 2; end
                    else m_lv[k] = m_lv[k] + m_atk;
                end
                2: begin
                    if (m_dcy == 0 || m_lv[k] - m_dcy <= m_sus) begin m_lv[k] = m_sus; m_st[k] = 3; end
                    else m_lv[k] = m_lv[k] - m_dcy;
                end
                3: m_lv[k] = m_sus;
                4: begin
                    if (m_rel == 0 || m_lv[k] <= m_rel) begin m_lv[k] = 0; m_st[k] = 0; end
                    else m_lv[k] = m_lv[k] - m_rel;
                end
                default: ;
            endcase
            m_pg[k]   = gt;
            exp_lv[k] = m_lv[k];
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'(m_ovr) << 16;
        for (int k = 0; k < NV; k++) if (m_st[k] != 0) s[k] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] model_voice(input int v);
        return (32'(m_st[v]) << 16) | 32'(m_lv[v]);
    endfunction

    task automatic wb_read(input logic [31:0] addr, output logic [31:0] data);
        int n;
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = addr;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!wb_ack_o && n < 8);
        if (!wb_ack_o) chk("wb_read_ack", 32'(wb_ack_o), 32'd1);
        data = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] addr, input logic [31:0] data);
        int n;
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = addr; wb_dat_i = data;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!wb_ack_o && n < 8);
        if (!wb_ack_o) chk("wb_write_ack", 32'(wb_ack_o), 32'd1);
        @(posedge clk); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        wb_read(addr, d);
        chk(tag, d, exp);
    endtask

    // Tick once and check the whole output stream; extra=1 fires a second
    // tick three cycles after the first, which must be ignored.
    task automatic run_scan(input bit extra);
        if (m_en != 0) model_scan();
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        if (m_en == 0) begin
            for (int k = 0; k <= NV; k++) begin
                @(negedge clk);
                chk("disabled_valid", 32'(env_valid), 32'd0);
            end
        end else begin
            for (int k = 0; k < NV; k++) begin
                @(negedge clk);
                chk("scan_valid", 32'(env_valid), 32'd1);
                chk("scan_voice", 32'(env_voice), 32'(k));
                chk("scan_level", 32'(env_level), 32'(exp_lv[k]));
                if (k == 0) last_v0 = env_level;
                if (extra && k == 1) begin @(posedge clk); #1 sample_tick = 1'b1; m_ovr = 1; end
                if (extra && k == 2) begin @(posedge clk); #1 sample_tick = 1'b0; end
            end
            @(negedge clk);
            chk("scan_end_valid", 32'(env_valid), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] d;
        int att_exp [4];
        int guard;
        att_exp = '{'h4000, 'h8000, 'hC000, 'hFFFF};

        rst_n = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0;
        voice_gate = '0; sample_tick = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_env_valid", 32'(env_valid), 32'd0);
        chk("rst_env_voice", 32'(env_voice), 32'd0);
        chk("rst_env_level", 32'(env_level), 32'd0);
        chk("rst_wb_ack",    32'(wb_ack_o),  32'd0);
        chk("rst_wb_dat",    wb_dat_o,       32'd0);
        rst_n = 1'b1;

        // Register reset values and address decode
        read_chk("rd_ctrl",    32'h00, 32'h1);
        read_chk("rd_attack",  32'h04, 32'h100);
        read_chk("rd_decay",   32'h08, 32'h40);
        read_chk("rd_sustain", 32'h0C, 32'hC000);
        read_chk("rd_release", 32'h10, 32'h20);
        read_chk("rd_status",  32'h14, 32'h0);
        read_chk("rd_unmapped", 32'h18, 32'hDEADBEEF);
        read_chk("rd_past_voices", 32'h20 + 4 * NV, 32'hDEADBEEF);
        wb_write(32'h18, 32'h1234);
        read_chk("rd_unmapped_after_wr", 32'h18, 32'hDEADBEEF);

        // Attack to full scale
        wb_write(32'h04, 32'h4000); m_atk = 'h4000;
        voice_gate = 8'h01;
        for (int i = 0; i < 4; i++) begin
            run_scan(1'b0);
            chk("attack_v0", 32'(last_v0), 32'(att_exp[i]));
        end
        read_chk("v0_decay_state", 32'h20, 32'h0002FFFF);

        // Decay into sustain, then live sustain change
        wb_write(32'h08, 32'h2000); m_dcy = 'h2000;
        run_scan(1'b0); chk("decay_v0_1", 32'(last_v0), 32'hDFFF);
        run_scan(1'b0); chk("decay_v0_2", 32'(last_v0), 32'hC000);
        read_chk("v0_sustain_state", 32'h20, 32'h0003C000);
        wb_write(32'h0C, 32'h8000); m_sus = 'h8000;
        run_scan(1'b0); chk("sustain_track", 32'(last_v0), 32'h8000);

        // Release to idle
        wb_write(32'h10, 32'h3000); m_rel = 'h3000;
        voice_gate = 8'h00;
        run_scan(1'b0); chk("release_v0_1", 32'(last_v0), 32'h5000);
        run_scan(1'b0); chk("release_v0_2", 32'(last_v0), 32'h2000);
        run_scan(1'b0); chk("release_v0_3", 32'(last_v0), 32'h0000);
        read_chk("v0_idle_reg", 32'h20, 32'h0);
        read_chk("status_idle", 32'h14, 32'h0);

        // Retrigger during release keeps the level
        voice_gate = 8'h01;
        guard = 0;
        while (m_st[0] != 3 && guard < 20) begin
            run_scan(1'b0);
            guard++;
        end
        read_chk("v0_back_sustain", 32'h20, 32'h00038000);
        voice_gate = 8'h00;
        run_scan(1'b0); chk("retrig_release", 32'(last_v0), 32'h5000);
        voice_gate = 8'h01;
        run_scan(1'b0); chk("retrig_attack", 32'(last_v0), 32'h9000);
        read_chk("v0_retrig_state", 32'h20, 32'h00019000);

        // Overrun
        run_scan(1'b1);
        wb_read(32'h14, d);
        chk("ovr_set_bit", 32'(d[16]), 32'd1);
        chk("ovr_status", d, model_status());
        wb_write(32'h14, 32'h10000); m_ovr = 0;
        read_chk("ovr_cleared", 32'h14, model_status());

        // Randomized envelopes against the model
        for (int it = 0; it < 40; it++) begin
            int r, val;
            voice_gate = NV'($urandom);
            r = int'($urandom_range(0, 9));
            val = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 'h4000));
            case (r)
                0: begin wb_write(32'h04, 32'(val)); m_atk = val; end
                1: begin wb_write(32'h08, 32'(val)); m_dcy = val; end
                2: begin val = int'($urandom_range(0, MAX)); wb_write(32'h0C, 32'(val)); m_sus = val; end
                3: begin wb_write(32'h10, 32'(val)); m_rel = val; end
                4: begin m_en = (m_en == 0) ? 1 : 0; wb_write(32'h00, 32'(m_en)); end
                default: ;
            endcase
            run_scan(1'b0);
            if (it % 5 == 4) begin
                int v;
                v = int'($urandom_range(0, NV - 1));
                read_chk("rand_voice_reg", 32'h20 + 32'(4 * v), model_voice(v));
                read_chk("rand_status", 32'h14, model_status());
            end
        end
        wb_write(32'h00, 32'h1); m_en = 1;

        // Asynchronous reset in the middle of a scan
        voice_gate = '1;
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("midscan_valid", 32'(env_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(env_valid), 32'd0);
        chk("async_rst_level", 32'(env_level), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        voice_gate = '0;
        read_chk("post_rst_status", 32'h14, 32'h0);
        read_chk("post_rst_attack", 32'h04, 32'h100);
        read_chk("post_rst_v0", 32'h20, 32'h0);
        @(negedge clk);
        chk("post_rst_valid", 32'(env_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
